// File: rtl/program_sequencer_if.sv
// Fetch/decode handshake between the program sequencer, program memory and decoder.
interface program_sequencer_if #(
  parameter int unsigned PC_WIDTH = 8
);
  logic                jmp;
  logic                jmp_nz;
  logic [3:0]          jmp_addr;
  logic                dont_jmp;
  logic                pm_ready;
  logic                halt_req;
  logic                step_req;
  logic [PC_WIDTH-1:0] pm_addr;
  logic [PC_WIDTH-1:0] pc;
  logic                instr_valid;
  logic                halted;
  logic                fetch_err;

  // Sequencer side: drives fetch address, pc and status.
  modport master (
    input  jmp, jmp_nz, jmp_addr, dont_jmp, pm_ready, halt_req, step_req,
    output pm_addr, pc, instr_valid, halted, fetch_err
  );

  // Decoder / memory / debug side.
  modport slave (
    output jmp, jmp_nz, jmp_addr, dont_jmp, pm_ready, halt_req, step_req,
    input  pm_addr, pc, instr_valid, halted, fetch_err
  );
endinterface

// File: rtl/program_sequencer.sv
// Program counter and fetch sequencing: FETCH waits on pm_ready, EXEC resolves jumps,
// HALT provides debug halt/single-step and traps fetch timeouts.
module program_sequencer #(
  parameter int unsigned PC_WIDTH   = 8,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input logic                clk,
  input logic                reset_n,
  program_sequencer_if.master bus
);

  typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

  localparam logic [7:0]          WaitLast = 8'(WAIT_LIMIT - 1);
  localparam logic [PC_WIDTH-1:0] PcOne    = PC_WIDTH'(1);

  state_e              r_state, w_state_next;
  logic [PC_WIDTH-1:0] r_pc, w_pc_next;
  logic [7:0]          r_wait_cnt, w_wait_cnt_next;
  logic                r_instr_valid, w_instr_valid_next;
  logic                r_fetch_err, w_fetch_err_next;
  logic                r_step_pending, w_step_pending_next;
  logic                r_step_q;
  logic                w_step_edge;
  logic                w_take_jump;

  assign w_step_edge = bus.step_req & ~r_step_q;
  // jmp wins over jmp_nz; both target the same in-page address.
  assign w_take_jump = bus.jmp | (bus.jmp_nz & ~bus.dont_jmp);

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= StFetch;
      r_pc           <= '0;
      r_wait_cnt     <= '0;
      r_instr_valid  <= 1'b0;
      r_fetch_err    <= 1'b0;
      r_step_pending <= 1'b0;
      r_step_q       <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_pc           <= w_pc_next;
      r_wait_cnt     <= w_wait_cnt_next;
      r_instr_valid  <= w_instr_valid_next;
      r_fetch_err    <= w_fetch_err_next;
      r_step_pending <= w_step_pending_next;
      r_step_q       <= bus.step_req;
    end
  end

  // Next-state logic for the fetch/exec/halt sequencer.
  always_comb begin
    w_state_next        = r_state;
    w_pc_next           = r_pc;
    w_wait_cnt_next     = '0;
    w_instr_valid_next  = 1'b0;
    w_fetch_err_next    = r_fetch_err;
    w_step_pending_next = r_step_pending;

    unique case (r_state)
      StFetch: begin
        if (bus.pm_ready) begin
          w_state_next       = StExec;
          w_instr_valid_next = 1'b1;
        end else if (r_wait_cnt == WaitLast) begin
          // Memory never answered: trap in HALT until reset.
          w_fetch_err_next = 1'b1;
          w_state_next     = StHalt;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 8'd1;
        end
      end

      StExec: begin
        if (w_take_jump) begin
          w_pc_next = {r_pc[PC_WIDTH-1:4], bus.jmp_addr};
        end else begin
          w_pc_next = r_pc + PcOne;
        end
        if (bus.halt_req || r_step_pending) begin
          w_state_next        = StHalt;
          w_step_pending_next = 1'b0;
        end else begin
          w_state_next = StFetch;
        end
      end

      StHalt: begin
        if (!r_fetch_err) begin
          if (w_step_edge) begin
            w_step_pending_next = 1'b1;
            w_state_next        = StFetch;
          end else if (!bus.halt_req) begin
            w_state_next = StFetch;
          end
        end
      end

      default: w_state_next = StFetch;
    endcase
  end

  assign bus.pc          = r_pc;
  assign bus.pm_addr     = r_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.halted      = (r_state == StHalt);
  assign bus.fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: free run, jump table, fetch latency, halt/step,
// async reset and fetch timeout trap.
module tb_program_sequencer;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  program_sequencer_if #(.PC_WIDTH(8)) bus ();

  program_sequencer #(
    .PC_WIDTH  (8),
    .WAIT_LIMIT(15)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       jmp;
    logic       jmp_nz;
    logic       dont_jmp;
    logic [3:0] addr;
    logic [7:0] exp_pc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Run one instruction from a FETCH negedge; ends on the negedge after EXEC.
  task automatic exec_instr(input logic j, input logic jnz, input logic dz, input logic [3:0] a,
                            input logic [7:0] exp_pc, input string name);
    bit seen = 0;
    bus.jmp = j; bus.jmp_nz = jnz; bus.dont_jmp = dz; bus.jmp_addr = a;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.instr_valid) seen = 1;
    end
    if (!seen) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      check({name, "_pc"}, 32'(bus.pc), 32'(exp_pc));
      check({name, "_pm_addr"}, 32'(bus.pm_addr), 32'(exp_pc));
      check({name, "_iv_low"}, 32'(bus.instr_valid), 32'd0);
    end
    bus.jmp = 0; bus.jmp_nz = 0; bus.dont_jmp = 0; bus.jmp_addr = 4'h0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One step_req pulse from HALT; expects exactly one instruction, then HALT again.
  task automatic do_step(input logic [7:0] exp_pc, input string name);
    int n_iv = 0;
    bit back = 0;
    bus.step_req = 1'b1;
    @(negedge clk);
    bus.step_req = 1'b0;
    for (int i = 0; i < 12 && !back; i++) begin
      @(negedge clk);
      if (bus.instr_valid) n_iv++;
      if (bus.halted) back = 1;
    end
    check({name, "_rehalted"}, 32'(back), 32'd1);
    check({name, "_pc"}, 32'(bus.pc), 32'(exp_pc));
    check({name, "_iv_count"}, 32'(n_iv), 32'd1);
  endtask

  vec_t vecs[16];
  logic exp_iv[6];
  logic [7:0] exp_fr_pc[6];

  initial begin
    int n_iv;

    vecs[0]  = '{1, 0, 0, 4'hF, 8'h0F};
    vecs[1]  = '{0, 0, 0, 4'h0, 8'h10};
    vecs[2]  = '{1, 0, 0, 4'hF, 8'h1F};
    vecs[3]  = '{0, 0, 0, 4'h0, 8'h20};
    vecs[4]  = '{1, 0, 0, 4'hF, 8'h2F};
    vecs[5]  = '{1, 0, 0, 4'h5, 8'h25};  // jmp
    vecs[6]  = '{1, 0, 0, 4'hF, 8'h2F};
    vecs[7]  = '{0, 1, 0, 4'h5, 8'h25};  // jmp_nz taken
    vecs[8]  = '{1, 0, 0, 4'hF, 8'h2F};
    vecs[9]  = '{0, 1, 1, 4'h5, 8'h30};  // jmp_nz suppressed, carry into high nibble
    vecs[10] = '{0, 1, 0, 4'hA, 8'h3A};
    vecs[11] = '{1, 1, 1, 4'h3, 8'h33};  // jmp wins, zero flag ignored
    vecs[12] = '{0, 0, 0, 4'h0, 8'h34};
    vecs[13] = '{0, 0, 0, 4'h9, 8'h35};  // addr ignored without jump
    vecs[14] = '{0, 0, 1, 4'h1, 8'h36};
    vecs[15] = '{1, 0, 1, 4'h7, 8'h37};

    exp_iv    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_fr_pc = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03};

    reset_n = 1'b0;
    bus.jmp = 0; bus.jmp_nz = 0; bus.dont_jmp = 0; bus.jmp_addr = 4'h0;
    bus.pm_ready = 1'b1; bus.halt_req = 1'b0; bus.step_req = 1'b0;

    // Reset values
    #1;
    check("rst_pc", 32'(bus.pc), 32'h0);
    check("rst_pm_addr", 32'(bus.pm_addr), 32'h0);
    check("rst_iv", 32'(bus.instr_valid), 32'h0);
    check("rst_halted", 32'(bus.halted), 32'h0);
    check("rst_fetch_err", 32'(bus.fetch_err), 32'h0);

    // Free run with pm_ready tied high
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("freerun%0d_iv", i), 32'(bus.instr_valid), 32'(exp_iv[i]));
      check($sformatf("freerun%0d_pc", i), 32'(bus.pc), 32'(exp_fr_pc[i]));
    end

    // Jump resolution table
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      exec_instr(vecs[i].jmp, vecs[i].jmp_nz, vecs[i].dont_jmp, vecs[i].addr, vecs[i].exp_pc,
                 $sformatf("vec%0d", i));
    end

    // Walk pages up to 0xF0, then wrap 0xFF -> 0x00
    exec_instr(0, 0, 0, 4'h0, 8'h38, "walk_pre");
    for (int k = 0; k < 12; k++) begin
      exec_instr(1, 0, 0, 4'hF, {4'(3 + k), 4'hF}, $sformatf("walk%0d_jmp", k));
      exec_instr(0, 0, 0, 4'h0, {4'(4 + k), 4'h0}, $sformatf("walk%0d_inc", k));
    end
    exec_instr(1, 0, 0, 4'hF, 8'hFF, "to_ff");
    exec_instr(0, 0, 0, 4'h0, 8'h00, "wrap");

    // pm_ready low for 3 cycles
    bus.pm_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("lat%0d_iv", i), 32'(bus.instr_valid), 32'd0);
      check($sformatf("lat%0d_pc", i), 32'(bus.pc), 32'h00);
    end
    bus.pm_ready = 1'b1;
    @(negedge clk);
    check("lat_iv_after_ready", 32'(bus.instr_valid), 32'd1);
    check("lat_pc_in_exec", 32'(bus.pc), 32'h00);
    @(negedge clk);
    check("lat_pc_next", 32'(bus.pc), 32'h01);
    check("lat_iv_drop", 32'(bus.instr_valid), 32'd0);

    // Halt at pc=4, then single steps
    apply_reset();
    for (int i = 1; i <= 4; i++) exec_instr(0, 0, 0, 4'h0, 8'(i), $sformatf("pre_halt%0d", i));
    bus.halt_req = 1'b1;
    exec_instr(0, 0, 0, 4'h0, 8'h05, "halt_exec4");
    check("halt_halted", 32'(bus.halted), 32'd1);
    n_iv = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.instr_valid) n_iv++;
    end
    check("halt_frozen_pc", 32'(bus.pc), 32'h05);
    check("halt_no_iv", 32'(n_iv), 32'd0);
    check("halt_still", 32'(bus.halted), 32'd1);

    do_step(8'h06, "step1");
    do_step(8'h07, "step2");

    // step_req held high: exactly one instruction
    bus.step_req = 1'b1;
    n_iv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.instr_valid) n_iv++;
    end
    bus.step_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.instr_valid) n_iv++;
    end
    check("stephold_iv_count", 32'(n_iv), 32'd1);
    check("stephold_pc", 32'(bus.pc), 32'h08);
    check("stephold_halted", 32'(bus.halted), 32'd1);

    // Release halt: free run resumes
    bus.halt_req = 1'b0;
    @(negedge clk);
    check("resume_halted", 32'(bus.halted), 32'd0);
    repeat (2) @(negedge clk);
    check("resume_pc", 32'(bus.pc), 32'h09);

    // Async reset mid-fetch at pc=9
    bus.pm_ready = 1'b0;
    @(negedge clk);
    check("midfetch_pc", 32'(bus.pc), 32'h09);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_pc", 32'(bus.pc), 32'h0);
    check("async_rst_halted", 32'(bus.halted), 32'd0);
    check("async_rst_fetch_err", 32'(bus.fetch_err), 32'd0);
    @(negedge clk);
    bus.pm_ready = 1'b1;
    reset_n = 1'b1;

    // Fetch timeout trap at pc=1
    exec_instr(0, 0, 0, 4'h0, 8'h01, "pre_timeout");
    bus.pm_ready = 1'b0;
    repeat (14) @(negedge clk);
    check("timeout14_err", 32'(bus.fetch_err), 32'd0);
    check("timeout14_halted", 32'(bus.halted), 32'd0);
    @(negedge clk);
    check("timeout15_err", 32'(bus.fetch_err), 32'd1);
    check("timeout15_halted", 32'(bus.halted), 32'd1);
    check("timeout15_pc", 32'(bus.pc), 32'h01);

    // Trap ignores steps and halt release
    bus.pm_ready = 1'b1;
    bus.step_req = 1'b1;
    @(negedge clk);
    bus.step_req = 1'b0;
    n_iv = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.instr_valid) n_iv++;
    end
    check("trap_halted", 32'(bus.halted), 32'd1);
    check("trap_pc", 32'(bus.pc), 32'h01);
    check("trap_no_iv", 32'(n_iv), 32'd0);
    check("trap_err_sticky", 32'(bus.fetch_err), 32'd1);

    // Reset clears the trap
    #2 reset_n = 1'b0;
    #1;
    check("trap_rst_err", 32'(bus.fetch_err), 32'd0);
    check("trap_rst_halted", 32'(bus.halted), 32'd0);
    check("trap_rst_pc", 32'(bus.pc), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    exec_instr(0, 0, 0, 4'h0, 8'h01, "post_trap_run");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
